// File: rtl/axi_llc_data_way_pipe.sv
// ---------------------------------------------------------------------------
// axi_llc_data_way_pipe
//
// One data way of the LLC: a word-addressed storage array with byte-enable
// writes and a fixed-latency read pipeline feeding a small response FIFO.
// Reads are credit-limited so the FIFO can never overflow even when the
// response side stalls; writes never produce a response.
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : request handshake
//   req_unit_i              : routing tag returned with read data
//   req_line_i, req_blk_i   : word address = {line, blk}
//   req_we_i, req_data_i,
//   req_strb_i              : write enable, write data, byte enables
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_unit_o, rsp_data_o  : response tag and read data
//   busy_o                  : at least one read in flight or buffered
// ---------------------------------------------------------------------------
package axi_llc_pkg;
    typedef enum logic [1:0] {
        EvictUnit = 2'd0,
        RefilUnit = 2'd1,
        RwUnit    = 2'd2
    } cache_unit_e;
endpackage

module axi_llc_data_way_pipe #(
    parameter int unsigned IndexLength       = 8,
    parameter int unsigned BlockOffsetLength = 2,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned Latency           = 2,
    parameter int unsigned RspDepth          = Latency,
    parameter type         unit_t            = axi_llc_pkg::cache_unit_e
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  unit_t                        req_unit_i,
    input  logic [IndexLength-1:0]       req_line_i,
    input  logic [BlockOffsetLength-1:0] req_blk_i,
    input  logic                         req_we_i,
    input  logic [DataWidth-1:0]         req_data_i,
    input  logic [DataWidth/8-1:0]       req_strb_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output unit_t                        rsp_unit_o,
    output logic [DataWidth-1:0]         rsp_data_o,
    output logic                         busy_o
);
    localparam int unsigned AddrWidth = IndexLength + BlockOffsetLength;
    localparam int unsigned NumWords  = 1 << AddrWidth;
    localparam int unsigned NumBytes  = DataWidth / 8;
    localparam int unsigned PipeRegs  = (Latency > 1) ? Latency - 1 : 1;
    localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RspDepth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RspDepth - 1);

    logic [AddrWidth-1:0] addr;
    logic                 acc_wr;
    logic                 acc_rd;
    logic                 pop;
    logic                 push_valid;
    unit_t                push_unit;

    logic [DataWidth-1:0] mem [NumWords];
    logic [DataWidth-1:0] fifo_data_mem [RspDepth];
    unit_t                fifo_unit_mem [RspDepth];

    logic [PtrWidth-1:0]  wptr_reg;
    logic [PtrWidth-1:0]  rptr_reg;
    logic [CntWidth-1:0]  cnt_reg;
    logic [CntWidth-1:0]  out_reg;

    assign addr   = {req_line_i, req_blk_i};
    assign acc_wr = req_valid_i && req_ready_o && req_we_i;
    assign acc_rd = req_valid_i && req_ready_o && !req_we_i;
    assign pop    = rsp_valid_o && rsp_ready_i;

    // A pop in this cycle returns its credit immediately, so a full buffer
    // being drained keeps reads flowing without a bubble.
    assign req_ready_o = req_we_i || (out_reg < DepthCnt) || pop;
    assign busy_o      = (out_reg != '0);
    assign rsp_valid_o = (cnt_reg != '0);
    assign rsp_unit_o  = rsp_valid_o ? fifo_unit_mem[rptr_reg]
                                     : unit_t'(axi_llc_pkg::EvictUnit);
    assign rsp_data_o  = rsp_valid_o ? fifo_data_mem[rptr_reg] : '0;

    // Byte-enable write port; storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (req_strb_i[b]) begin
                    mem[addr][b*8 +: 8] <= req_data_i[b*8 +: 8];
                end
            end
        end
    end

    // The FIFO entry write counts as the final register stage, so the read
    // path holds Latency-1 pipeline registers in front of it.
    generate
        if (Latency == 1) begin : g_direct
            assign push_valid = acc_rd;
            assign push_unit  = req_unit_i;

            always_ff @(posedge clk_i) begin
                if (acc_rd) begin
                    fifo_data_mem[wptr_reg] <= mem[addr];
                end
            end
        end else begin : g_pipe
            logic                 valid_reg [PipeRegs];
            unit_t                unit_reg  [PipeRegs];
            logic [DataWidth-1:0] data_reg  [PipeRegs];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < PipeRegs; k++) valid_reg[k] <= 1'b0;
                end else begin
                    valid_reg[0] <= acc_rd;
                    for (int k = 1; k < PipeRegs; k++) valid_reg[k] <= valid_reg[k-1];
                end
            end

            always_ff @(posedge clk_i) begin
                unit_reg[0] <= req_unit_i;
                data_reg[0] <= mem[addr];
                for (int k = 1; k < PipeRegs; k++) begin
                    unit_reg[k] <= unit_reg[k-1];
                    data_reg[k] <= data_reg[k-1];
                end
            end

            assign push_valid = valid_reg[PipeRegs-1];
            assign push_unit  = unit_reg[PipeRegs-1];

            always_ff @(posedge clk_i) begin
                if (push_valid) begin
                    fifo_data_mem[wptr_reg] <= data_reg[PipeRegs-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (push_valid) begin
            fifo_unit_mem[wptr_reg] <= push_unit;
        end
    end

    // Pointers wrap at RspDepth, which need not be a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            cnt_reg  <= '0;
            out_reg  <= '0;
        end else begin
            if (push_valid) wptr_reg <= (wptr_reg == LastPtr) ? '0 : wptr_reg + 1'b1;
            if (pop)        rptr_reg <= (rptr_reg == LastPtr) ? '0 : rptr_reg + 1'b1;
            cnt_reg <= cnt_reg + CntWidth'(push_valid) - CntWidth'(pop);
            out_reg <= out_reg + CntWidth'(acc_rd) - CntWidth'(pop);
        end
    end
endmodule

// File: tb/tb_axi_llc_data_way_pipe.sv
// ---------------------------------------------------------------------------
// tb_axi_llc_data_way_pipe
//
// Four instances with Latency = RspDepth = 1..4 (instance 1 uses the default
// Latency 2 / RspDepth 2). A reference memory and a queue of outstanding
// reads predict, every cycle, rsp_valid (head read has aged Latency cycles),
// req_ready (credit rule), busy and the response tag/data.
// ---------------------------------------------------------------------------
module tb_axi_llc_data_way_pipe;
    import axi_llc_pkg::*;

    typedef struct {
        logic [63:0] data;
        cache_unit_e unit;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid [4];
    logic        req_ready [4];
    cache_unit_e req_unit  [4];
    logic [7:0]  req_line  [4];
    logic [1:0]  req_blk   [4];
    logic        req_we    [4];
    logic [63:0] req_data  [4];
    logic [7:0]  req_strb  [4];
    logic        rsp_valid [4];
    logic        rsp_ready [4];
    cache_unit_e rsp_unit  [4];
    logic [63:0] rsp_data  [4];
    logic        busy      [4];

    logic [63:0] ref_mem [4][1024];
    exp_t        sb_q [$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc_rd = 0;
    int n_acc_wr = 0;
    int n_pop    = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        axi_llc_data_way_pipe #(
            .Latency  (gi + 1),
            .RspDepth (gi + 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (req_valid[gi]),
            .req_ready_o (req_ready[gi]),
            .req_unit_i  (req_unit[gi]),
            .req_line_i  (req_line[gi]),
            .req_blk_i   (req_blk[gi]),
            .req_we_i    (req_we[gi]),
            .req_data_i  (req_data[gi]),
            .req_strb_i  (req_strb[gi]),
            .rsp_valid_o (rsp_valid[gi]),
            .rsp_ready_i (rsp_ready[gi]),
            .rsp_unit_o  (rsp_unit[gi]),
            .rsp_data_o  (rsp_data[gi]),
            .busy_o      (busy[gi])
        );
    end

    task automatic chk(input string tag, input int i, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst=%0d cyc=%0d: observed=%h expected=%h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic we, input int a,
                         input logic [63:0] d, input logic [7:0] s, input cache_unit_e u);
        req_valid[i] = v;
        req_we[i]    = we;
        req_line[i]  = 8'(a >> 2);
        req_blk[i]   = 2'(a);
        req_data[i]  = d;
        req_strb[i]  = s;
        req_unit[i]  = u;
    endtask

    // One clock cycle of instance i: check outputs against the model at the
    // falling edge, then retire pops and record accepted requests.
    task automatic tick(input int i);
        logic        exp_valid;
        logic        exp_ready;
        logic        pop_e;
        logic [63:0] exp_data;
        cache_unit_e exp_unit;
        int          a;
        exp_t        e;
        @(negedge clk);
        exp_valid = (sb_q.size() != 0) && (cyc >= sb_q[0].cyc + i + 1);
        exp_data  = exp_valid ? sb_q[0].data : 64'h0;
        exp_unit  = exp_valid ? sb_q[0].unit : EvictUnit;
        pop_e     = exp_valid && rsp_ready[i];
        exp_ready = req_we[i] || (sb_q.size() < i + 1) || pop_e;
        chk("rsp_valid", i, 64'(rsp_valid[i]), 64'(exp_valid));
        chk("req_ready", i, 64'(req_ready[i]), 64'(exp_ready));
        chk("busy",      i, 64'(busy[i]),      64'(sb_q.size() != 0));
        chk("rsp_unit",  i, 64'(rsp_unit[i]),  64'(exp_unit));
        chk("rsp_data",  i, rsp_data[i],       exp_data);
        if (pop_e) begin
            $display("rsp  inst=%0d cyc=%0d unit=%0d data=%h", i, cyc, exp_unit, exp_data);
            void'(sb_q.pop_front());
            n_pop++;
        end
        if (req_valid[i] && req_ready[i]) begin
            a = {22'd0, req_line[i], req_blk[i]};
            if (req_we[i]) begin
                for (int b = 0; b < 8; b++)
                    if (req_strb[i][b]) ref_mem[i][a][b*8 +: 8] = req_data[i][b*8 +: 8];
                n_acc_wr++;
            end else begin
                e.data = ref_mem[i][a];
                e.unit = req_unit[i];
                e.cyc  = cyc;
                sb_q.push_back(e);
                n_acc_rd++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
        end
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += n;
        sb_q.delete();
    endtask

    initial begin
        int base_rd;
        int base_wr;
        int base_pop;
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b0, 1'b0, 0, 64'h0, 8'h00, RwUnit);
            rsp_ready[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset for two cycles, then idle state.
        do_reset(2);
        tick(1);

        // Strobe write then read of address 5.
        rsp_ready[1] = 1'b1;
        drive(1, 1'b1, 1'b1, 5, 64'h1111_2222_3333_4444, 8'hFF, RwUnit);
        tick(1);
        drive(1, 1'b1, 1'b1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, RwUnit);
        tick(1);
        drive(1, 1'b1, 1'b0, 5, 64'h0, 8'h00, RwUnit);
        tick(1);
        drive(1, 1'b0, 1'b0, 0, 64'h0, 8'h00, RwUnit);
        repeat (3) tick(1);
        chk("strobe_queue_empty", 1, 64'(sb_q.size()), 64'd0);

        // Streaming: preload 16 words, then 16 back-to-back reads.
        for (int a = 0; a < 16; a++) begin
            drive(1, 1'b1, 1'b1, a, {$urandom, $urandom}, 8'hFF, EvictUnit);
            tick(1);
        end
        base_rd  = n_acc_rd;
        base_pop = n_pop;
        for (int a = 0; a < 16; a++) begin
            drive(1, 1'b1, 1'b0, a, 64'h0, 8'h00, cache_unit_e'(a % 3));
            tick(1);
        end
        chk("stream_accepts", 1, 64'(n_acc_rd - base_rd), 64'd16);
        drive(1, 1'b0, 1'b0, 0, 64'h0, 8'h00, RwUnit);
        repeat (4) tick(1);
        chk("stream_responses", 1, 64'(n_pop - base_pop), 64'd16);

        // Backpressure: reads stall after two credits, writes keep flowing.
        rsp_ready[1] = 1'b0;
        base_rd = n_acc_rd;
        for (int k = 0; k < 5; k++) begin
            drive(1, 1'b1, 1'b0, k, 64'h0, 8'h00, RefilUnit);
            tick(1);
        end
        chk("bp_reads_accepted", 1, 64'(n_acc_rd - base_rd), 64'd2);
        base_wr = n_acc_wr;
        drive(1, 1'b1, 1'b1, 9, 64'hA5A5_5A5A_0123_4567, 8'hFF, RefilUnit);
        tick(1);
        chk("bp_write_accepted", 1, 64'(n_acc_wr - base_wr), 64'd1);
        rsp_ready[1] = 1'b1;
        base_rd = n_acc_rd;
        drive(1, 1'b1, 1'b0, 9, 64'h0, 8'h00, RwUnit);
        tick(1);
        chk("bp_resume_same_cycle", 1, 64'(n_acc_rd - base_rd), 64'd1);
        drive(1, 1'b0, 1'b0, 0, 64'h0, 8'h00, RwUnit);
        repeat (4) tick(1);

        // Mid-flight reset: three reads, one more cycle, then reset.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 1'b0, k, 64'h0, 8'h00, RwUnit);
            tick(1);
        end
        drive(1, 1'b0, 1'b0, 0, 64'h0, 8'h00, RwUnit);
        tick(1);
        do_reset(1);
        rsp_ready[1] = 1'b1;
        repeat (10) tick(1);

        // Latency sweep with random request and response traffic.
        for (int i = 0; i < 4; i++) begin
            do_reset(2);
            for (int a = 0; a < 16; a++) begin
                rsp_ready[i] = 1'($urandom_range(0, 1));
                drive(i, 1'b1, 1'b1, a, {$urandom, $urandom}, 8'hFF, EvictUnit);
                tick(i);
            end
            for (int k = 0; k < 300; k++) begin
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                drive(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 15)), {$urandom, $urandom},
                      8'($urandom), cache_unit_e'($urandom_range(0, 2)));
                tick(i);
            end
            drive(i, 1'b0, 1'b0, 0, 64'h0, 8'h00, RwUnit);
            rsp_ready[i] = 1'b1;
            repeat (12) tick(i);
            chk("sweep_drained", i, 64'(sb_q.size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
